// File: rtl/align_job_scheduler.sv
// ---------------------------------------------------------------------------
// align_job_scheduler
//
// Purpose:
//   Round-robin scheduler that shares one systolic alignment solver among
//   NUM_REQ requesters. For each job it grants one requester and drives that
//   requester's lengths and index to the solver. It then holds the solver in
//   reset for CLEAR_CYCLES cycles and keeps the solver enabled until the solver
//   reports finished. Finally it returns the max-score coordinates on a
//   valid/ready response channel.
//
// Optional feature:
//   ALIGN_SCHED_TIMEOUT_EN - when defined, a watchdog counts RUN cycles. After
//   TIMEOUT_CYCLES cycles without solver_finished the job ends with
//   rsp_err=2'b10 and row=col=0. When undefined, RUN waits for finished
//   indefinitely.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req                    per-requester level request, held until its rsp
//                          handshake completes
//   req_len1, req_len2     packed per-requester sequence lengths
//   grant, sel_id          one-hot owner / index of the granted requester
//   solver_rst             solver reset (high in all states except RUN)
//   solver_enable          solver enable (high only in RUN, never gapped)
//   solver_len1/2          latched lengths of the granted job
//   solver_finished        solver done strobe/level
//   solver_max_row/col     solver max-score coordinates
//   rsp_valid, rsp_ready   response handshake
//   rsp_id, rsp_row,       response payload; rsp_err: 00 ok, 01 zero
//   rsp_col, rsp_err       length, 10 timeout
// ---------------------------------------------------------------------------
module align_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int LEN_W          = 8,
    parameter int COORD_W        = 8,
    parameter int CLEAR_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len1,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len2,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(NUM_REQ)-1:0]    sel_id,
    output logic                          solver_rst,
    output logic                          solver_enable,
    output logic [LEN_W-1:0]              solver_len1,
    output logic [LEN_W-1:0]              solver_len2,
    input  logic                          solver_finished,
    input  logic [COORD_W-1:0]            solver_max_row,
    input  logic [COORD_W-1:0]            solver_max_col,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [COORD_W-1:0]            rsp_row,
    output logic [COORD_W-1:0]            rsp_col,
    output logic [1:0]                    rsp_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_RESULT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]      sel_id_q, sel_id_d;
    logic                 solver_rst_q, solver_rst_d;
    logic                 solver_enable_q, solver_enable_d;
    logic [LEN_W-1:0]     len1_q, len1_d;
    logic [LEN_W-1:0]     len2_q, len2_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [COORD_W-1:0]   rsp_row_q, rsp_row_d;
    logic [COORD_W-1:0]   rsp_col_q, rsp_col_d;
    logic [1:0]           rsp_err_q, rsp_err_d;

    // Arbitration results
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      win_id;
    logic [ID_W:0]        win_sum;
    logic                 win_found;
    logic [LEN_W-1:0]     win_len1;
    logic [LEN_W-1:0]     win_len2;
    logic                 win_zero;
    logic                 timeout_hit;

`ifdef ALIGN_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]     timer_q, timer_d;

    // Watchdog: counts RUN cycles and is zero whenever we are not in RUN,
    // so it is implicitly cleared on RUN entry.
    always_comb begin
        timer_d     = '0;
        timeout_hit = 1'b0;
        if (state_q == S_RUN) begin
            timer_d     = timer_q + TMR_W'(1);
            timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Round-robin pick: rotate the request vector so the rr pointer sits at
    // bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        req_dbl   = {req, req} >> rr_q;
        req_rot   = req_dbl[NUM_REQ-1:0];
        win_found = 1'b0;
        win_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, rr_q} + (ID_W+1)'(i);
            end
        end
        if (win_sum >= (ID_W+1)'(NUM_REQ)) begin
            win_sum = win_sum - (ID_W+1)'(NUM_REQ);
        end
        win_id   = win_sum[ID_W-1:0];
        win_len1 = '0;
        win_len2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_len1 = req_len1[i*LEN_W +: LEN_W];
                win_len2 = req_len2[i*LEN_W +: LEN_W];
            end
        end
        win_zero = (win_len1 == '0) || (win_len2 == '0);
    end

    // State register plus every registered output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            clr_cnt_q       <= '0;
            rr_q            <= '0;
            grant_q         <= '0;
            sel_id_q        <= '0;
            solver_rst_q    <= 1'b1;
            solver_enable_q <= 1'b0;
            len1_q          <= '0;
            len2_q          <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_row_q       <= '0;
            rsp_col_q       <= '0;
            rsp_err_q       <= '0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            rr_q            <= rr_d;
            grant_q         <= grant_d;
            sel_id_q        <= sel_id_d;
            solver_rst_q    <= solver_rst_d;
            solver_enable_q <= solver_enable_d;
            len1_q          <= len1_d;
            len2_q          <= len2_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_row_q       <= rsp_row_d;
            rsp_col_q       <= rsp_col_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    // Next-state logic. A zero-length job skips the solver entirely.
    // solver_finished is only looked at in RUN, so an early finished level
    // from the previous job cannot end the new one.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d   = win_zero ? S_RESULT : S_CLEAR;
                    clr_cnt_d = CNT_W'(CLEAR_CYCLES - 1);
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (solver_finished || timeout_hit) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. Outputs are derived from the next state so they are all
    // registered yet line up with the state they belong to.
    always_comb begin
        grant_d         = grant_q;
        sel_id_d        = sel_id_q;
        len1_d          = len1_q;
        len2_d          = len2_q;
        rr_d            = rr_q;
        rsp_id_d        = rsp_id_q;
        rsp_row_d       = rsp_row_q;
        rsp_col_d       = rsp_col_q;
        rsp_err_d       = rsp_err_q;
        solver_rst_d    = (state_d != S_RUN);
        solver_enable_d = (state_d == S_RUN);
        rsp_valid_d     = (state_d == S_RESULT);

        if (state_q == S_IDLE && win_found) begin
            grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
            sel_id_d = win_id;
            len1_d   = win_len1;
            len2_d   = win_len2;
            if (win_zero) begin
                rsp_id_d  = win_id;
                rsp_row_d = '0;
                rsp_col_d = '0;
                rsp_err_d = 2'b01;
            end
        end

        // Finished wins over a coincident timeout.
        if (state_q == S_RUN && state_d == S_RESULT) begin
            rsp_id_d = sel_id_q;
            if (solver_finished) begin
                rsp_row_d = solver_max_row;
                rsp_col_d = solver_max_col;
                rsp_err_d = 2'b00;
            end else begin
                rsp_row_d = '0;
                rsp_col_d = '0;
                rsp_err_d = 2'b10;
            end
        end

        // The served requester becomes lowest priority for the next round.
        if (state_q == S_RESULT && state_d == S_IDLE) begin
            grant_d = '0;
            if (sel_id_q == ID_W'(NUM_REQ - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = sel_id_q + ID_W'(1);
            end
        end
    end

    assign grant         = grant_q;
    assign sel_id        = sel_id_q;
    assign solver_rst    = solver_rst_q;
    assign solver_enable = solver_enable_q;
    assign solver_len1   = len1_q;
    assign solver_len2   = len2_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_row       = rsp_row_q;
    assign rsp_col       = rsp_col_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_align_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_align_job_scheduler
//
// Directed bench for align_job_scheduler (NUM_REQ=4, CLEAR_CYCLES=2,
// TIMEOUT_CYCLES=20). Inputs change 1 ns after the rising edge, and outputs
// are checked at that point. Expected values are hand-derived from the
// intended timing:
//   - The grant appears one edge after a request is seen in IDLE.
//   - solver_rst stays high for two grant cycles.
//   - rsp_valid rises one edge after finished.
//   - The grant drops one edge after the handshake.
// ---------------------------------------------------------------------------
module tb_align_job_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_len1;
    logic [31:0] req_len2;
    logic [3:0]  grant;
    logic [1:0]  sel_id;
    logic        solver_rst;
    logic        solver_enable;
    logic [7:0]  solver_len1;
    logic [7:0]  solver_len2;
    logic        solver_finished;
    logic [7:0]  solver_max_row;
    logic [7:0]  solver_max_col;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_row;
    logic [7:0]  rsp_col;
    logic [1:0]  rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    align_job_scheduler #(
        .NUM_REQ(4), .LEN_W(8), .COORD_W(8), .CLEAR_CYCLES(2), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_len1(req_len1), .req_len2(req_len2),
        .grant(grant), .sel_id(sel_id), .solver_rst(solver_rst),
        .solver_enable(solver_enable), .solver_len1(solver_len1),
        .solver_len2(solver_len2), .solver_finished(solver_finished),
        .solver_max_row(solver_max_row), .solver_max_col(solver_max_col),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_row(rsp_row), .rsp_col(rsp_col), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] l1,
                                 input logic [31:0] l2);
        req      = r;
        req_len1 = l1;
        req_len2 = l2;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        req             = '0;
        req_len1        = '0;
        req_len2        = '0;
        rsp_ready       = 1'b0;
        solver_finished = 1'b0;
        solver_max_row  = '0;
        solver_max_col  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Full job from IDLE with a request already applied
    task automatic run_job(input logic [3:0] exp_grant, input logic [1:0] exp_id,
                           input logic [7:0] row, input logic [7:0] col);
        tick();
        checkOutput("job_grant", grant, exp_grant);
        checkOutput("job_sel_id", sel_id, exp_id);
        tick();
        tick();
        checkOutput("job_enable", solver_enable, 1);
        solver_finished = 1'b1;
        solver_max_row  = row;
        solver_max_col  = col;
        tick();
        solver_finished = 1'b0;
        checkOutput("job_rsp_valid", rsp_valid, 1);
        checkOutput("job_rsp_id", rsp_id, exp_id);
        checkOutput("job_rsp_rowcol", {rsp_row, rsp_col}, {row, col});
        checkOutput("job_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("job_release_grant", grant, 0);
        checkOutput("job_release_valid", rsp_valid, 0);
    endtask

    initial begin
        int n;

        // ---------------- reset values ----------------
        do_reset();
        rst = 1'b1;
        tick();
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_solver_rst", solver_rst, 1);
        checkOutput("rst_enable", solver_enable, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_fields", {rsp_id, rsp_row, rsp_col, rsp_err}, 0);
        checkOutput("rst_lens", {solver_len1, solver_len2}, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_no_req_grant", grant, 0);

        // ---------------- single job on requester 2 ----------------
        applyStimulus(4'b0100, 32'h0005_0000, 32'h0005_0000);
        tick();
        checkOutput("s1_grant", grant, 4'b0100);
        checkOutput("s1_sel_id", sel_id, 2);
        checkOutput("s1_lens", {solver_len1, solver_len2}, 16'h0505);
        checkOutput("s1_clear0_rst", solver_rst, 1);
        solver_finished = 1'b1;
        tick();
        checkOutput("s1_clear1_rst", solver_rst, 1);
        checkOutput("s1_clear1_en", solver_enable, 0);
        tick();
        checkOutput("s1_run_rst", solver_rst, 0);
        checkOutput("s1_run_en", solver_enable, 1);
        checkOutput("s1_early_finish_ignored", rsp_valid, 0);
        solver_finished = 1'b0;
        tick();
        checkOutput("s1_run_en2", solver_enable, 1);
        solver_finished = 1'b1;
        solver_max_row  = 8'd4;
        solver_max_col  = 8'd3;
        tick();
        solver_finished = 1'b0;
        checkOutput("s1_rsp_valid", rsp_valid, 1);
        checkOutput("s1_rsp_id", rsp_id, 2);
        checkOutput("s1_rsp_rowcol", {rsp_row, rsp_col}, 16'h0403);
        checkOutput("s1_rsp_err", rsp_err, 0);
        checkOutput("s1_result_en", solver_enable, 0);
        checkOutput("s1_result_rst", solver_rst, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req       = '0;
        checkOutput("s1_release_grant", grant, 0);
        checkOutput("s1_release_valid", rsp_valid, 0);

        // ---------------- fairness after service ----------------
        do_reset();
        applyStimulus(4'b0011, 32'h0101_0101, 32'h0202_0202);
        run_job(4'b0001, 2'd0, 8'd1, 8'd2);
        run_job(4'b0010, 2'd1, 8'd3, 8'd4);

        // ---------------- contention 1111 ----------------
        do_reset();
        applyStimulus(4'b1111, 32'h0303_0303, 32'h0404_0404);
        run_job(4'b0001, 2'd0, 8'h10, 8'h11);
        run_job(4'b0010, 2'd1, 8'h12, 8'h13);
        run_job(4'b0100, 2'd2, 8'h14, 8'h15);
        run_job(4'b1000, 2'd3, 8'h16, 8'h17);
        run_job(4'b0001, 2'd0, 8'h18, 8'h19);
        req = '0;

        // ---------------- zero length ----------------
        do_reset();
        applyStimulus(4'b0010, 32'h0000_0700, 32'h0000_0000);
        tick();
        checkOutput("z_grant", grant, 4'b0010);
        checkOutput("z_rsp_valid", rsp_valid, 1);
        checkOutput("z_rsp_id", rsp_id, 1);
        checkOutput("z_rsp_err", rsp_err, 2'b01);
        checkOutput("z_rsp_rowcol", {rsp_row, rsp_col}, 0);
        checkOutput("z_enable", solver_enable, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("z_release_grant", grant, 0);
        checkOutput("z_release_enable", solver_enable, 0);

        // ---------------- backpressure (rr pointer now 2) ----------------
        applyStimulus(4'b0101, 32'h0009_0009, 32'h0009_0009);
        run_job(4'b0100, 2'd2, 8'd0, 8'd0);
        // rr pointer now 3, so requester 0 wins next
        tick();
        checkOutput("bp_grant", grant, 4'b0001);
        tick();
        tick();
        solver_finished = 1'b1;
        solver_max_row  = 8'd9;
        solver_max_col  = 8'd10;
        tick();
        solver_finished = 1'b0;
        solver_max_row  = 8'h55;
        solver_max_col  = 8'h66;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold_valid", rsp_valid, 1);
            checkOutput("bp_hold_payload", {rsp_id, rsp_row, rsp_col, rsp_err},
                        {2'd0, 8'd9, 8'd10, 2'b00});
            checkOutput("bp_hold_grant", grant, 4'b0001);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("bp_release_grant", grant, 0);
        checkOutput("bp_release_valid", rsp_valid, 0);

        // ---------------- reset mid-RUN (rr pointer now 1) ----------------
        tick();
        checkOutput("mr_grant", grant, 4'b0100);
        tick();
        tick();
        checkOutput("mr_run_en", solver_enable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        checkOutput("mr_grant_cleared", grant, 0);
        checkOutput("mr_sel_cleared", sel_id, 0);
        checkOutput("mr_solver_rst", solver_rst, 1);
        checkOutput("mr_enable", solver_enable, 0);
        checkOutput("mr_lens", {solver_len1, solver_len2}, 0);
        tick();
        checkOutput("mr_no_rsp", rsp_valid, 0);

        // ---------------- watchdog / no watchdog ----------------
        applyStimulus(4'b0001, 32'h0000_0020, 32'h0000_0020);
        tick();
        checkOutput("to_grant", grant, 4'b0001);
        tick();
        tick();
        checkOutput("to_run_en", solver_enable, 1);
        n = 0;
        while (solver_enable && n < 40) begin
            n++;
            tick();
        end
`ifdef ALIGN_SCHED_TIMEOUT_EN
        checkOutput("to_run_cycles", n, 20);
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_rsp_err", rsp_err, 2'b10);
        checkOutput("to_rsp_rowcol", {rsp_row, rsp_col}, 0);
        checkOutput("to_solver_rst", solver_rst, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("to_release_grant", grant, 0);
`else
        checkOutput("noto_run_cycles", n, 40);
        checkOutput("noto_still_waiting", rsp_valid, 0);
        checkOutput("noto_grant_held", grant, 4'b0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/align_job_scheduler.md
Name: align_job_scheduler

Overview:
- Round-robin scheduler that shares one systolic alignment solver (solver array + backtrace) among NUM_REQ requesters.
- Per job, in order: grants one requester, drives its lengths and sequence-select index to the solver, clears the solver with a reset pulse, holds solver enable until the solver reports finished, then returns the max-score coordinates on a valid/ready response channel.
- Sits between the host-side job queues and the solver top level.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
LEN_W, 8, width of length fields (signed in solver, values 0..2^(LEN_W-1)-1)
COORD_W, 8, width of result row/column fields
CLEAR_CYCLES, 2, cycles solver_rst is held before each job (>=1)
TIMEOUT_CYCLES, 65535, watchdog limit in RUN (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester job request, level; held until its rsp handshake completes
req_len1  in  NUM_REQ*LEN_W  packed seq1 length per requester; stable while req high
req_len2  in  NUM_REQ*LEN_W  packed seq2 length per requester; stable while req high
grant  out  NUM_REQ  one-hot owner of the solver, 0 when idle
sel_id  out  $clog2(NUM_REQ)  index of the granted requester, steers the external sequence mux
solver_rst  out  1  reset to the solver
solver_enable  out  1  solver enable
solver_len1  out  LEN_W  registered len1 of the granted job
solver_len2  out  LEN_W  registered len2 of the granted job
solver_finished  in  1  solver backtrace finished
solver_max_row  in  COORD_W  solver maxRowId
solver_max_col  in  COORD_W  solver maxColId
rsp_valid  out  1  result valid
rsp_ready  in  1  result accepted
rsp_id  out  $clog2(NUM_REQ)  requester the result belongs to
rsp_row  out  COORD_W  captured max row
rsp_col  out  COORD_W  captured max column
rsp_err  out  2  result status: 00 ok, 01 zero length, 10 timeout

Behaviour:
- Reset values: state=IDLE; grant=0; sel_id=0; solver_rst=1; solver_enable=0; solver_len1/2=0; rsp_valid=0; rsp_id/row/col/err=0; rr pointer=0. Reset mid-job aborts the job with no response.
- All outputs are registered.
- IDLE:
  - solver_rst=1, solver_enable=0.
  - If any req is high, pick the first set bit searching from the rr pointer upward with wrap-around.
  - Next cycle: grant=onehot(winner), sel_id=winner, lengths latched.
  - If either latched length == 0: go to RESULT with rsp_err=01, row=col=0, and no solver activity.
  - Otherwise go to CLEAR.
  - No req: stay in IDLE.
- CLEAR: solver_rst=1 for exactly CLEAR_CYCLES cycles (down-counter), then go to RUN.
- RUN:
  - solver_rst=0; solver_enable=1 continuously. The solver requires at least two consecutive enabled cycles; the enable is never gapped.
  - When solver_finished is sampled high: register solver_max_row/col into rsp_row/col, rsp_err=00, go to RESULT. rsp_valid rises the cycle after finished is seen.
  - solver_finished high before RUN has been entered is ignored.
- RESULT:
  - rsp_valid=1; rsp_id=sel_id; solver_enable=0; solver_rst=1. The solver is held in reset, and its outputs need not stay stable.
  - rsp_* stay stable until rsp_ready.
  - On the rsp_valid&&rsp_ready cycle: next cycle rsp_valid=0, grant=0, rr pointer=winner+1 (mod NUM_REQ), state=IDLE.
- Arbitration fairness: a requester that has just been served is lowest priority next round. A continuously requesting requester waits at most NUM_REQ-1 jobs.
- A requester dropping req while granted is ignored; the job completes and its response is still delivered.
- Simultaneous handshake completion and a new req: the new req is arbitrated in the following IDLE cycle. Minimum gap between grants is 1 IDLE cycle.
- grant never changes outside IDLE entry/exit. sel_id is stable from grant assertion until grant deassertion.

Optional Feature:
- Macro: ALIGN_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RUN, cleared on RUN entry.
  - If it reaches TIMEOUT_CYCLES without solver_finished: go to RESULT with rsp_err=10, row=col=0, and solver_rst asserted the next cycle.
  - If finished and timeout land in the same cycle, finished wins.
- Undefined: no counter; RUN waits for finished indefinitely; rsp_err=10 never occurs.

Test Plan:
- Single job, NUM_REQ=4: req[2], len1=5, len2=5 -> grant=0100, sel_id=2, solver_rst high 2 cycles, solver_enable held; finished with row=4,col=3 -> rsp_valid, rsp_id=2, row=4, col=3, err=00; after ready, grant=0.
- Contention: req=1111 held continuously -> grants in order 0,1,2,3,0; each response id matches the grant.
- Fairness after service: req=0011, pointer at 0 -> grant 0; after its response, req still 0011 -> grant 1 (not 0).
- Zero length: req[1] with len2=0 -> solver_enable never rises; rsp err=01, row=col=0, within 2 cycles of grant.
- Backpressure: rsp_ready low for 10 cycles -> rsp_* stable, grant held, other reqs not granted; ready high -> release.
- Reset mid-RUN, plus timeout with ALIGN_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20:
  - rst during RUN -> all outputs return to reset values next cycle, no response.
  - finished never arrives -> err=10 after 20 RUN cycles.
